// File: rtl/ibex_mem_arbiter.sv
// Round-robin bridge from the Ibex instruction and data ports onto one single-port
// RAM with 1-cycle read latency. Checks address range and routes responses back.
module ibex_mem_arbiter #(
  parameter int unsigned Depth    = 16384,
  parameter logic [31:0] BaseAddr = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [31:0]              data_addr_i,
  input  logic [31:0]              data_wdata_i,
  output logic                     data_gnt_o,
  output logic                     data_rvalid_o,
  output logic [31:0]              data_rdata_o,
  output logic                     data_err_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [$clog2(Depth)-1:0] mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i,
  output logic                     protocol_err_o
);

  localparam int unsigned AW    = $clog2(Depth);
  localparam logic [32:0] Limit = 33'(Depth) * 33'd4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  typedef enum logic {
    LAST_INSTR = 1'b0,
    LAST_DATA  = 1'b1
  } last_e;

  owner_e r_owner;
  logic   r_err;
  last_e  r_last;
  logic   r_protocol_err;

  logic [31:0] w_instr_off;
  logic [31:0] w_data_off;
  logic        w_instr_in;
  logic        w_data_in;
  logic        w_gnt_instr;
  logic        w_gnt_data;
  logic        w_mem_instr;
  logic        w_mem_data;
  logic        w_resp_ok;
  logic        w_protocol_viol;
  logic        w_unused_bits;

  // Offsets wrap modulo 2^32, so addresses below BaseAddr land far out of range.
  assign w_instr_off = instr_addr_i - BaseAddr;
  assign w_data_off  = data_addr_i - BaseAddr;
  assign w_instr_in  = {1'b0, w_instr_off} < Limit;
  assign w_data_in   = {1'b0, w_data_off} < Limit;

  assign w_unused_bits = ^{w_instr_off[31:AW+2], w_instr_off[1:0],
                           w_data_off[31:AW+2], w_data_off[1:0]};

  // Under contention the port that did not win last time takes the slot.
  assign w_gnt_data  = reset & data_req_i  & (~instr_req_i | (r_last == LAST_INSTR));
  assign w_gnt_instr = reset & instr_req_i & (~data_req_i  | (r_last == LAST_DATA));

  assign instr_gnt_o = w_gnt_instr;
  assign data_gnt_o  = w_gnt_data;

  assign w_mem_instr = w_gnt_instr & w_instr_in;
  assign w_mem_data  = w_gnt_data & w_data_in;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (w_mem_data) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = w_data_off[AW+1:2];
      mem_wdata_o = data_wdata_i;
    end else if (w_mem_instr) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = w_instr_off[AW+1:2];
    end
  end

  // A grant tracked with no RAM reply, or a RAM reply nobody asked for.
  assign w_protocol_viol = (mem_rvalid_i & ((r_owner == OWN_NONE) | r_err)) |
                           ((r_owner != OWN_NONE) & ~r_err & ~mem_rvalid_i);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner        <= OWN_NONE;
      r_err          <= 1'b0;
      r_last         <= LAST_INSTR;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_gnt_data) begin
        r_owner <= OWN_DATA;
        r_err   <= ~w_data_in;
        r_last  <= LAST_DATA;
      end else if (w_gnt_instr) begin
        r_owner <= OWN_INSTR;
        r_err   <= ~w_instr_in;
        r_last  <= LAST_INSTR;
      end else begin
        r_owner <= OWN_NONE;
        r_err   <= 1'b0;
      end
      if (w_protocol_viol) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // Error responses complete on their own; RAM responses wait for mem_rvalid_i.
  assign w_resp_ok = reset & (r_err | mem_rvalid_i);

  assign instr_rvalid_o = w_resp_ok & (r_owner == OWN_INSTR);
  assign data_rvalid_o  = w_resp_ok & (r_owner == OWN_DATA);
  assign instr_err_o    = instr_rvalid_o & r_err;
  assign data_err_o     = data_rvalid_o & r_err;
  assign instr_rdata_o  = (instr_rvalid_o & ~r_err) ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o & ~r_err) ? mem_rdata_i : 32'h0;

  assign protocol_err_o = reset & r_protocol_err;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed plus randomized bench for ibex_mem_arbiter against a transaction-level
// model of grants, RAM contents and expected responses.
module tb_ibex_mem_arbiter;

  localparam int          DEPTH = 16384;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [31:0]   instr_rdata_o;
  logic          instr_err_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          data_err_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i  = 32'h0;
  logic          protocol_err_o;

  logic inject;
  logic clear_ram;

  ibex_mem_arbiter #(.Depth(DEPTH), .BaseAddr(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  // Single-port RAM with 1-cycle read latency; writes return the old word.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    mem_rvalid_i <= mem_req_o | inject;
    if (clear_ram) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
    end else if (mem_req_o) begin
      mem_rdata_i <= ram[mem_addr_o];
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          last_was_data;
  bit          cur_valid;
  bit          cur_is_data;
  bit          cur_err;
  logic [31:0] cur_data;
  bit          mr_now;
  bit          sticky;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dwe, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd, input bit inj);
    bit          g_i, g_d, in_i, in_d, e_req, e_rv, e_iv, e_dv;
    logic [31:0] off_i, off_d, e_addr, e_rdata;
    int          idx;
    reset = rst; instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dwe; data_be_i = dbe;
    data_addr_i = da; data_wdata_i = dwd; inject = inj;

    off_i = ia - BASE;
    off_d = da - BASE;
    in_i  = off_i < LIMIT;
    in_d  = off_d < LIMIT;
    g_d   = rst && dr && (!ir || !last_was_data);
    g_i   = rst && ir && !g_d;
    e_req = (g_d && in_d) || (g_i && in_i);
    e_addr = (g_d ? off_d : off_i) >> 2;
    e_rv  = rst && cur_valid && (cur_err || mr_now);
    e_iv  = e_rv && !cur_is_data;
    e_dv  = e_rv && cur_is_data;
    e_rdata = cur_err ? 32'h0 : cur_data;

    @(negedge clk);
    if (g_i || g_d)
      $display("t=%0t grant %s addr=%08h in_range=%0d", $time, g_d ? "data " : "instr",
               g_d ? da : ia, g_d ? in_d : in_i);
    check("instr_gnt", 32'(instr_gnt_o), 32'(g_i));
    check("data_gnt", 32'(data_gnt_o), 32'(g_d));
    check("mem_req", 32'(mem_req_o), 32'(e_req));
    if (e_req || !rst) begin
      check("mem_addr", 32'(mem_addr_o), e_req ? e_addr : 32'h0);
      check("mem_we", 32'(mem_we_o), (e_req && g_d) ? 32'(dwe) : 32'h0);
      check("mem_be", 32'(mem_be_o), !e_req ? 32'h0 : (g_d ? 32'(dbe) : 32'hF));
      if (g_d || !rst) check("mem_wdata", mem_wdata_o, e_req ? dwd : 32'h0);
    end
    check("instr_rvalid", 32'(instr_rvalid_o), 32'(e_iv));
    check("data_rvalid", 32'(data_rvalid_o), 32'(e_dv));
    check("instr_rdata", instr_rdata_o, e_iv ? e_rdata : 32'h0);
    check("data_rdata", data_rdata_o, e_dv ? e_rdata : 32'h0);
    if (e_iv) check("instr_err", 32'(instr_err_o), 32'(cur_err));
    if (e_dv) check("data_err", 32'(data_err_o), 32'(cur_err));
    check("protocol_err", 32'(protocol_err_o), 32'(rst && sticky));

    @(posedge clk);
    if (rst && ((mr_now && (!cur_valid || cur_err)) || (cur_valid && !cur_err && !mr_now)))
      sticky = 1'b1;
    if (!rst) sticky = 1'b0;
    mr_now = e_req || inj;
    if (g_i || g_d) begin
      cur_valid   = 1'b1;
      cur_is_data = g_d;
      cur_err     = g_d ? !in_d : !in_i;
      idx         = int'(e_addr);
      cur_data    = cur_err ? 32'h0 : ref_mem[idx];
      if (g_d && in_d && dwe)
        for (int b = 0; b < 4; b++)
          if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      last_was_data = g_d;
    end else begin
      cur_valid = 1'b0;
    end
    if (!rst) last_was_data = 1'b0;
    #1;
  endtask

  task automatic idle();                 step(1, 0, 0, 0, 0, 4'h0, 0, 0, 0); endtask
  task automatic rst_cycle();            step(0, 0, 0, 0, 0, 4'h0, 0, 0, 0); endtask
  task automatic fetch(input logic [31:0] a); step(1, 1, a, 0, 0, 4'h0, 0, 0, 0); endtask
  task automatic load(input logic [31:0] a);  step(1, 0, 0, 1, 0, 4'hF, a, 0, 0); endtask
  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    step(1, 0, 0, 1, 1, be, a, wd, 0);
  endtask
  task automatic both(input logic [31:0] ia, input logic [31:0] da);
    step(1, 1, ia, 1, 0, 4'hF, da, 0, 0);
  endtask

  initial begin
    reset = 1'b0; instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0; inject = 1'b0; clear_ram = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    last_was_data = 1'b0; cur_valid = 1'b0; cur_is_data = 1'b0; cur_err = 1'b0;
    cur_data = 32'h0; mr_now = 1'b0; sticky = 1'b0;
    @(posedge clk);
    #1;
    clear_ram = 1'b0;

    rst_cycle(); rst_cycle();

    // Instruction fetch of a preloaded word
    store(32'h80, 4'hF, 32'h1234_5678);
    idle();
    fetch(32'h80);
    idle();

    // Contention straight after reset alternates D, I, D, I
    rst_cycle();
    both(32'h80, 32'h84); both(32'h84, 32'h88); both(32'h83, 32'h8C); both(32'h81, 32'h90);
    idle();

    // Partial store then read back
    store(32'h100, 4'b0011, 32'hDEAD_BEEF);
    idle();
    load(32'h100);
    idle();

    // Out-of-range load, then one just inside the top of memory
    load(32'h0001_0000);
    idle();
    load(32'h0000_FFFC);
    fetch(32'hFFFF_FFFC);
    idle();

    // Reset lands on an in-flight response; data wins first contention afterwards
    load(32'h200);
    step(0, 1, 32'h0, 1, 0, 4'hF, 32'h200, 0, 0);
    both(32'h0, 32'h80);
    both(32'h4, 32'h84);
    idle();

    // Spurious RAM response sets the sticky flag until reset
    idle();
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
    idle(); idle();
    fetch(32'h80); load(32'h100); idle();
    rst_cycle();
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit          r_rst, r_ir, r_dr, r_we;
      logic [31:0] r_ia, r_da;
      r_rst = ($urandom_range(0, 39) != 0);
      r_ir  = 1'($urandom_range(0, 1));
      r_dr  = 1'($urandom_range(0, 1));
      r_we  = 1'($urandom_range(0, 1));
      r_ia  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, DEPTH * 4 - 1);
      r_da  = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, 255) * 4;
      step(r_rst, r_ir, r_ia, r_dr, r_we, 4'($urandom_range(0, 15)), r_da, $urandom, 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
